pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Consumes the combinational hazard flag from the ID-stage hazard detection logic, plus branch and SRAM-wait events.
- Produces the freeze, bubble and flush controls applied to the PC, IF/ID, ID/EX, EXE/MEM and MEM/WB pipeline registers.
- Arbitrates simultaneous stall sources, tracks multi-cycle memory waits with an FSM and timeout watchdog, and keeps saturating performance counters.
- Sits in the top-level ARM core beside the hazard detection unit, between the stage datapaths and their pipeline registers.

Parameters:
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_timeout_err is raised.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- hazard_detected_signal  input  1  RAW hazard flag for the instruction in ID.
- branch_taken  input  1  taken branch resolved in EXE this cycle.
- mem_req  input  1  MEM stage is issuing an SRAM read or write this cycle.
- mem_ready  input  1  SRAM completion strobe.
- freeze_pc  output  1  hold PC.
- freeze_if_id  output  1  hold IF/ID register.
- bubble_id_ex  output  1  load zeroed control (NOP) into ID/EX.
- flush_if_id  output  1  clear IF/ID to NOP.
- freeze_back  output  1  hold ID/EX, EXE/MEM and MEM/WB during a memory wait.
- state_mem_wait  output  1  FSM is in MEM_WAIT.
- mem_timeout_err  output  1  sticky watchdog error.
- stall_cycles  output  CNT_W  count of hazard-stall cycles.
- flush_count  output  CNT_W  count of branch flushes.
- mem_wait_cycles  output  CNT_W  count of memory-freeze cycles.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to RUN; timeout counter = 0; all counters = 0; mem_timeout_err = 0.
  - All control outputs evaluate to 0, since no inputs are active out of reset.
- FSM states:
  - RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req=1 and mem_ready=0.
  - MEM_WAIT -> RUN on the first cycle with mem_ready=1.
  - A request that completes in its own cycle (mem_req=1, mem_ready=1) leaves the FSM in RUN with no freeze.
- Control outputs are combinational from the current state and the inputs, so they act in the same cycle with zero latency.
- Priority, highest first:
  1. Memory freeze: active when (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready). Then freeze_back=freeze_pc=freeze_if_id=1, and bubble_id_ex=flush_if_id=0. Branch and hazard inputs are ignored, because EXE holds its instruction and re-presents them after the wait.
  2. Branch flush: branch_taken=1 and no memory freeze. Then flush_if_id=1 and bubble_id_ex=1; freezes are 0, so the PC loads the branch target. A coincident hazard is ignored because the ID instruction is squashed.
  3. Hazard stall: hazard_detected_signal=1 with neither of the above. Then freeze_pc=1, freeze_if_id=1, bubble_id_ex=1.
  4. Otherwise all controls are 0.
- Memory-wait cycle in which mem_ready=1: no freeze. Priorities 2-3 apply normally in that same cycle.
- Watchdog:
  - Timeout counter increments each MEM_WAIT cycle with mem_ready=0, saturating at MEM_TIMEOUT.
  - On reaching MEM_TIMEOUT, mem_timeout_err is set (sticky until rst). The FSM keeps waiting; no forced exit.
  - Counter clears on exit to RUN.
- Performance counters:
  - Each saturates at all-ones; no wrap.
  - stall_cycles +1 per priority-3 cycle; flush_count +1 per priority-2 cycle; mem_wait_cycles +1 per priority-1 cycle.
- Reset mid-wait: the FSM returns to RUN immediately and freeze drops asynchronously.

Decomposition:
- Shared core package holds:
  - the FSM state encoding (ST_RUN=0, ST_MEM_WAIT=1);
  - the default MEM_TIMEOUT and CNT_W values.
- One sub-module is natural: sat_counter (enable, synchronous clear, saturate at all-ones, width parameter). It is instantiated for the three performance counters and the watchdog.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, counters 0, state_mem_wait=0.
- hazard_detected_signal=1 for 2 cycles -> freeze_pc=freeze_if_id=bubble_id_ex=1 both cycles; stall_cycles=2.
- branch_taken=1 and hazard=1 in the same cycle -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0; flush_count=1, stall_cycles unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> freeze_back=1 for 3 cycles and 0 on the 4th; state_mem_wait=1 for cycles 2-4; mem_wait_cycles=3; a branch_taken asserted during the wait gives no flush.
- MEM_TIMEOUT=4 with mem_ready held 0 for 10 cycles -> mem_timeout_err=1 from the cycle after the counter reaches 4 and stays 1 after mem_ready; freeze continues until mem_ready.
- rst pulsed mid-MEM_WAIT -> freeze_back=0 immediately, state RUN, counters 0, mem_timeout_err=0; CNT_W=4 with 20 hazard cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipeline_stall_controller_pkg.sv
// Purpose: shared FSM encoding and default sizing for the stall controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    // Longest tolerated SRAM wait before the watchdog flags an error.
    localparam int DEF_MEM_TIMEOUT = 255;
    // Width of each performance counter.
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Purpose: bundles hazard/branch/SRAM events and the pipeline-register controls.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-valid every cycle.
interface pipeline_stall_controller_if
    import pipeline_stall_controller_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    // Events from the stage datapaths
    logic             hazard_detected_signal;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    // Controls to the pipeline registers and status
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             bubble_id_ex;
    logic             flush_if_id;
    logic             freeze_back;
    logic             state_mem_wait;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] mem_wait_cycles;

    // Datapath side: raises events, consumes controls.
    modport master (
        output hazard_detected_signal, branch_taken, mem_req, mem_ready,
        input  freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back,
        input  state_mem_wait, mem_timeout_err,
        input  stall_cycles, flush_count, mem_wait_cycles
    );

    // Controller side.
    modport slave (
        input  hazard_detected_signal, branch_taken, mem_req, mem_ready,
        output freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back,
        output state_mem_wait, mem_timeout_err,
        output stall_cycles, flush_count, mem_wait_cycles
    );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Purpose: up-counter with synchronous clear that sticks at all-ones.
// Latency: count visible the cycle after the enabling edge.
// Backpressure: none; enable is sampled every cycle.
module sat_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Purpose: arbitrates memory-wait, branch-flush and hazard stalls into pipeline-register controls.
// Latency: controls are combinational (same cycle); counters/state update on the next edge.
// Backpressure: a pending SRAM access freezes the whole pipe until mem_ready.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_stall_controller_if.slave   bus
);

    // Watchdog is just wide enough to hold MEM_TIMEOUT; it stops there
    // rather than at all-ones.
    localparam int                TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e            state_q;
    state_e            state_d;
    logic              err_q;
    logic              err_d;

    logic              mem_freeze;
    logic              branch_flush;
    logic              hazard_stall;
    logic              tmo_inc;
    logic              tmo_clr;
    logic [TMO_W-1:0]  tmo_cnt;

    // Priority arbitration: memory freeze > branch flush > hazard stall.
    // A freeze hides branch/hazard because EXE re-presents them after the wait.
    always_comb begin
        mem_freeze   = 1'b0;
        branch_flush = 1'b0;
        hazard_stall = 1'b0;
        if (!bus.mem_ready) begin
            mem_freeze = (state_q == ST_MEM_WAIT) || bus.mem_req;
        end
        branch_flush = !mem_freeze && bus.branch_taken;
        hazard_stall = !mem_freeze && !bus.branch_taken && bus.hazard_detected_signal;
    end

    assign bus.freeze_back     = mem_freeze;
    assign bus.freeze_pc       = mem_freeze || hazard_stall;
    assign bus.freeze_if_id    = mem_freeze || hazard_stall;
    assign bus.bubble_id_ex    = branch_flush || hazard_stall;
    assign bus.flush_if_id     = branch_flush;
    assign bus.state_mem_wait  = (state_q == ST_MEM_WAIT);
    assign bus.mem_timeout_err = err_q;

    // Next state: enter MEM_WAIT on an access that did not complete in its own cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (bus.mem_req && !bus.mem_ready) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (bus.mem_ready)                 state_d = ST_RUN;
        endcase
    end

    // Watchdog controls; the error latches on the edge the count hits MEM_TIMEOUT
    // and the wait itself carries on.
    always_comb begin
        tmo_inc = (state_q == ST_MEM_WAIT) && !bus.mem_ready && (tmo_cnt != TMO_MAX);
        tmo_clr = (state_q == ST_MEM_WAIT) && bus.mem_ready;
        err_d   = err_q || (tmo_inc && (tmo_cnt == TMO_LAST));
    end

    // FSM and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .en  (tmo_inc),
        .clr (tmo_clr),
        .cnt (tmo_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (hazard_stall),
        .clr (1'b0),
        .cnt (bus.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (branch_flush),
        .clr (1'b0),
        .cnt (bus.flush_count)
    );

    sat_counter #(.W(CNT_W)) u_memw_cnt (
        .clk (clk),
        .rst (rst),
        .en  (mem_freeze),
        .clr (1'b0),
        .cnt (bus.mem_wait_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Purpose: self-checking bench for pipeline_stall_controller (vector table, corner sequences, random vs model).
// Latency: outputs sampled mid-cycle, 3 time units after inputs change.
// Backpressure: n/a.
module tb_pipeline_stall_controller;

    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

    pipeline_stall_controller #(
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: wait flag, length of the current stalled wait, sticky error,
    // and plain integer event tallies capped at SAT.
    bit m_wait;
    bit m_err;
    int m_len;
    int m_stall;
    int m_flush;
    int m_memw;

    typedef struct {
        bit             h, b, q, r;
        logic [6:0]     ctl;   // fpc, fifid, bubble, flush, fback, mem_wait, err
        logic [CW-1:0]  st, fl, mw;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_ex, bus.flush_if_id,
                bus.freeze_back, bus.state_mem_wait, bus.mem_timeout_err,
                bus.stall_cycles, bus.flush_count, bus.mem_wait_cycles};
    endfunction

    function automatic vec_t mk(input bit h, b, q, r, input logic [6:0] ctl,
                                input int st, fl, mw);
        vec_t v;
        v.h = h; v.b = b; v.q = q; v.r = r; v.ctl = ctl;
        v.st = CW'(st); v.fl = CW'(fl); v.mw = CW'(mw);
        return v;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_reset();
        m_wait = 1'b0; m_err = 1'b0; m_len = 0;
        m_stall = 0; m_flush = 0; m_memw = 0;
    endtask

    task automatic set_in(input bit h, b, q, r);
        bus.hazard_detected_signal = h;
        bus.branch_taken           = b;
        bus.mem_req                = q;
        bus.mem_ready              = r;
    endtask

    // Drive one cycle's inputs, compare against the model, then advance the model
    // as if the next edge had happened.
    task automatic apply(input bit h, b, q, r, input string name);
        bit frz, fl, st;
        logic [18:0] exp;
        set_in(h, b, q, r);
        #3;
        frz = !r && (m_wait || q);
        fl  = !frz && b;
        st  = !frz && !b && h;
        exp = {frz || st, frz || st, fl || st, fl, frz, m_wait, m_err,
               CW'(m_stall), CW'(m_flush), CW'(m_memw)};
        chk(name, 32'(dut_vec()), 32'(exp));
        if (st)  m_stall = sat_inc(m_stall);
        if (fl)  m_flush = sat_inc(m_flush);
        if (frz) m_memw  = sat_inc(m_memw);
        if (m_wait && !r) begin
            m_len++;
            if (m_len >= TMO) m_err = 1'b1;
        end
        if (m_wait) begin
            if (r) begin
                m_wait = 1'b0;
                m_len  = 0;
            end
        end else begin
            m_wait = q && !r;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        #2;
        chk("reset_state", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int lowp;
        rst = 1'b1;
        set_in(0, 0, 0, 0);

        //                h  b  q  r  ctl         st fl mw
        tbl[0]  = mk(0, 0, 0, 0, 7'b0000000, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 7'b1110000, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 7'b1110000, 1, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 7'b0011000, 2, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 7'b0000000, 2, 1, 0);
        tbl[5]  = mk(0, 0, 1, 0, 7'b1100100, 2, 1, 0);
        tbl[6]  = mk(0, 1, 1, 0, 7'b1100110, 2, 1, 1);
        tbl[7]  = mk(1, 0, 1, 0, 7'b1100110, 2, 1, 2);
        tbl[8]  = mk(0, 0, 1, 1, 7'b0000010, 2, 1, 3);
        tbl[9]  = mk(0, 0, 0, 0, 7'b0000000, 2, 1, 3);
        tbl[10] = mk(0, 0, 1, 1, 7'b0000000, 2, 1, 3);
        tbl[11] = mk(0, 0, 0, 0, 7'b0000000, 2, 1, 3);
        tbl[12] = mk(0, 0, 1, 0, 7'b1100100, 2, 1, 3);
        tbl[13] = mk(0, 1, 0, 1, 7'b0011010, 2, 1, 4);
        tbl[14] = mk(0, 0, 0, 0, 7'b0000000, 2, 2, 4);
        tbl[15] = mk(0, 0, 1, 0, 7'b1100100, 2, 2, 4);
        tbl[16] = mk(1, 0, 0, 1, 7'b1110010, 2, 2, 5);
        tbl[17] = mk(0, 0, 0, 0, 7'b0000000, 3, 2, 5);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].h, tbl[i].b, tbl[i].q, tbl[i].r);
            #3;
            chk($sformatf("vec%0d", i), 32'(dut_vec()),
                32'({tbl[i].ctl, tbl[i].st, tbl[i].fl, tbl[i].mw}));
            tick();
        end

        // Watchdog: ten stalled cycles, error from the sixth on, freeze until ready.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 1, 0, "tmo_wait");
            chk("tmo_err", 32'(bus.mem_timeout_err), 32'(i >= 5));
            chk("tmo_freeze", 32'(bus.freeze_back), 32'd1);
            tick();
        end
        apply(0, 0, 1, 1, "tmo_done");
        chk("tmo_done_freeze", 32'(bus.freeze_back), 32'd0);
        chk("tmo_done_err", 32'(bus.mem_timeout_err), 32'd1);
        tick();
        apply(0, 0, 0, 0, "tmo_after");
        chk("tmo_sticky", 32'(bus.mem_timeout_err), 32'd1);
        tick();

        // Asynchronous reset in the middle of a long wait.
        do_reset();
        apply(0, 0, 1, 0, "rmw_enter");
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, "rmw_wait");
            tick();
        end
        apply(0, 0, 0, 0, "rmw_last");
        chk("rmw_pre_freeze", 32'(bus.freeze_back), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmw_async_clear", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Counter saturation on a long hazard run.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1, 0, 0, 0, "sat_hazard");
            tick();
        end
        apply(0, 0, 0, 0, "sat_idle");
        chk("stall_sat", 32'(bus.stall_cycles), 32'(SAT));
        tick();

        // Random traffic against the model, with occasional resets and varying SRAM latency.
        do_reset();
        lowp = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) lowp = int'($urandom_range(1, 3));
            if ($urandom_range(0, 249) == 0) do_reset();
            apply($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)) >= lowp,
                  $sformatf("rnd%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
